// File: rtl/fp_left_shift_pipe.sv
// Pipelined power-of-two scaler: c = a * 2^b by raising the exponent field of a float.
// Latency 2 cycles accept->out_valid, throughput 1/cycle; stall (out_valid & ~out_ready) holds both stages.
// Optional FP_LSHIFT_STATS_EN adds saturating op_count/ovf_count outputs.
module fp_left_shift_pipe #(
   parameter int M = 23,
   parameter int E = 8,
   parameter int I = 8,
   localparam int SW = $clog2(I),
   localparam int W  = M + E + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [SW-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  c,
   output logic          ovf
`ifdef FP_LSHIFT_STATS_EN
   ,
   output logic [31:0]   op_count,
   output logic [15:0]   ovf_count
`endif
);

   // Largest exponent sum that still encodes a finite value is 2^E-2.
   localparam logic [E:0] EXP_INF = {1'b0, {E{1'b1}}};

   logic          stall;

   // Stage 1 registers
   logic          s1_vld_q;
   logic          s1_sign_q;
   logic [M-1:0]  s1_mant_q;
   logic [E:0]    s1_exp_sum_q;
   logic          s1_zero_q;
   logic          s1_special_q;
   logic [E:0]    exp_sum_d;

   // Stage 2 (output) registers
   logic          out_vld_q;
   logic [W-1:0]  c_q, c_d;
   logic          ovf_q, ovf_d;

   assign stall     = out_vld_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = out_vld_q;
   assign c         = c_q;
   assign ovf       = ovf_q;

   // One extra bit so the sum never wraps back into the finite range.
   assign exp_sum_d = {1'b0, a[M+E-1:M]} + {{(E+1-SW){1'b0}}, b};

   // Stage 1: split fields, add the shift, classify the input exponent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q     <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_mant_q    <= '0;
         s1_exp_sum_q <= '0;
         s1_zero_q    <= 1'b0;
         s1_special_q <= 1'b0;
      end else if (!stall) begin
         s1_vld_q <= in_valid;
         if (in_valid) begin
            s1_sign_q    <= a[W-1];
            s1_mant_q    <= a[M-1:0];
            s1_exp_sum_q <= exp_sum_d;
            s1_zero_q    <= (a[M+E-1:M] == '0);
            s1_special_q <= (a[M+E-1:M] == {E{1'b1}});
         end
      end
   end

   // Stage 2 result selection: special, then zero exponent, then saturation, then plain add.
   always_comb begin
      c_d   = {s1_sign_q, s1_exp_sum_q[E-1:0], s1_mant_q};
      ovf_d = 1'b0;
      if (s1_special_q) begin
         c_d = {s1_sign_q, {E{1'b1}}, s1_mant_q};
      end else if (s1_zero_q) begin
         c_d = {s1_sign_q, {E{1'b0}}, s1_mant_q};
      end else if (s1_exp_sum_q >= EXP_INF) begin
         c_d   = {s1_sign_q, {E{1'b1}}, {M{1'b0}}};
         ovf_d = 1'b1;
      end
   end

   // Stage 2: output register; c/ovf only move when a new result arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         c_q       <= '0;
         ovf_q     <= 1'b0;
      end else if (!stall) begin
         out_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            c_q   <= c_d;
            ovf_q <= ovf_d;
         end
      end
   end

`ifdef FP_LSHIFT_STATS_EN
   logic [31:0] op_count_q;
   logic [15:0] ovf_count_q;
   logic        out_xfer;

   assign out_xfer  = out_vld_q & out_ready;
   assign op_count  = op_count_q;
   assign ovf_count = ovf_count_q;

   // Saturating counters of output transfers and overflowed output transfers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_q  <= '0;
         ovf_count_q <= '0;
      end else if (out_xfer) begin
         if (op_count_q != '1) op_count_q <= op_count_q + 32'd1;
         if (ovf_q && (ovf_count_q != '1)) ovf_count_q <= ovf_count_q + 16'd1;
      end
   end
`endif

endmodule
